data_memory: RTL and testbench

- Single-port 32-bit data RAM for the processor datapath, sitting between the execute/memory stage and the register-file writeback path.
- Writes are synchronous on the rising clock edge when `write_enable` is asserted.
- Reads are combinational (asynchronous): `read_data` follows `addr` within the same cycle.
- Word-addressed: each address value selects one 32-bit word.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_byte_merge.sv | 24 ++
 rtl/data_memory.sv | 62 ++++++
 tb/tb_data_memory.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the processor data memory.
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 32;
  localparam int DMEM_DEPTH      = 1024;
  localparam int IDX_WIDTH       = $clog2(DMEM_DEPTH);
  localparam int LANE_WIDTH      = 8;

  typedef logic [DMEM_DATA_WIDTH-1:0] dmem_word_t;

endpackage

// File: rtl/dmem_byte_merge.sv
// Per-byte-lane merge of a stored word with incoming write data.
module dmem_byte_merge
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]            old_word,
  input  logic [DATA_WIDTH-1:0]            new_word,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] strobe,
  output logic [DATA_WIDTH-1:0]            merged_word
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (strobe[i]) begin
        merged_word[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/data_memory.sv
// Single-port word-addressed data RAM: synchronous write, combinational read, async clear.
// Optional per-byte write strobes when DMEM_BYTE_STROBE_EN is defined.
module data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           write_data,
  input  logic                            write_enable,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] byte_strobe,
`endif
  output logic [DATA_WIDTH-1:0]           read_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] wr_word;

  // Upper address bits only alias; they never select storage.
  assign idx = addr[IDX_W-1:0];

  generate
    if (ADDR_WIDTH > IDX_W) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IDX_W];
    end
  endgenerate

`ifdef DMEM_BYTE_STROBE_EN
  dmem_byte_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_byte_merge (
    .old_word    (mem[idx]),
    .new_word    (write_data),
    .strobe      (byte_strobe),
    .merged_word (wr_word)
  );
`else
  assign wr_word = write_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_enable) begin
      mem[idx] <= wr_word;
    end
  end

  assign read_data = mem[idx];

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (strobe test only with DMEM_BYTE_STROBE_EN).
module tb_data_memory;
  import dmem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   write_data;
  logic            write_enable;
  logic [DW-1:0]   read_data;
`ifdef DMEM_BYTE_STROBE_EN
  logic [DW/8-1:0] byte_strobe;
`endif

  int checks;
  int failures;

  data_memory #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_data   (write_data),
    .write_enable (write_enable),
`ifdef DMEM_BYTE_STROBE_EN
    .byte_strobe  (byte_strobe),
`endif
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
  endtask

  task automatic test_reset;
    dmem_word_t exp_w;
    rst = 1'b1;
    addr = 5;
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_initial addr5 got=%h exp=%h", read_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_write(5, 32'hDEADBEEF);
    exp_w = 32'hDEADBEEF;
    addr = 5;
    #1;
    checks++;
    if (read_data !== exp_w) begin
      failures++;
      $display("FAIL reset_prewrite addr5 got=%h exp=%h", read_data, exp_w);
    end
    // Pulse reset between edges: clear must happen with no clock.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_async_clear addr5 got=%h exp=%h", read_data, 32'h0);
    end
    // Writes are blocked while reset is held.
    write_data   = 32'hCAFEF00D;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_blocks_write addr5 got=%h exp=%h", read_data, 32'h0);
    end
    write_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_write;
    do_write(0, 32'h00000000);
    do_write(1, 32'h00000001);
    addr = 0;
    #1;
    checks++;
    if (read_data !== 32'h00000000) begin
      failures++;
      $display("FAIL basic_addr0 got=%h exp=%h", read_data, 32'h00000000);
    end
    addr = 1;
    #1;
    checks++;
    if (read_data !== 32'h00000001) begin
      failures++;
      $display("FAIL basic_addr1 got=%h exp=%h", read_data, 32'h00000001);
    end
  endtask

  task automatic test_write_disabled;
    @(negedge clk);
    write_enable = 1'b0;
    write_data   = 32'hFFFFFFFF;
    addr         = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (read_data !== 32'h00000001) begin
      failures++;
      $display("FAIL write_disabled addr1 got=%h exp=%h", read_data, 32'h00000001);
    end
  endtask

  task automatic test_read_during_write;
    do_write(7, 32'h11111111);
    @(negedge clk);
    addr         = 7;
    write_data   = 32'h22222222;
    write_enable = 1'b1;
    #1;
    checks++;
    if (read_data !== 32'h11111111) begin
      failures++;
      $display("FAIL rdw_before_edge got=%h exp=%h", read_data, 32'h11111111);
    end
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    checks++;
    if (read_data !== 32'h22222222) begin
      failures++;
      $display("FAIL rdw_after_edge got=%h exp=%h", read_data, 32'h22222222);
    end
  endtask

  task automatic test_aliasing;
    do_write(DEPTH + 3, 32'hA5A5A5A5);
    addr = 3;
    #1;
    checks++;
    if (read_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL alias_addr3 got=%h exp=%h", read_data, 32'hA5A5A5A5);
    end
    addr = 32'h8000_0003;
    #1;
    checks++;
    if (read_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL alias_high_bit got=%h exp=%h", read_data, 32'hA5A5A5A5);
    end
    do_write(DEPTH - 1, 32'h12345678);
    addr = DEPTH - 1;
    #1;
    checks++;
    if (read_data !== 32'h12345678) begin
      failures++;
      $display("FAIL top_index got=%h exp=%h", read_data, 32'h12345678);
    end
    addr = 0;
    #1;
    checks++;
    if (read_data !== 32'h00000000) begin
      failures++;
      $display("FAIL top_index_no_wrap addr0 got=%h exp=%h", read_data, 32'h00000000);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] exp_tab [4];
    exp_tab[0] = 32'h0BAD_0010;
    exp_tab[1] = 32'h0BAD_0011;
    exp_tab[2] = 32'hFFFF_0000;
    exp_tab[3] = 32'h0000_FFFF;
    @(negedge clk);
    write_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr       = 10 + i;
      write_data = exp_tab[i];
      @(negedge clk);
    end
    write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 10 + i;
      #1;
      checks++;
      if (read_data !== exp_tab[i]) begin
        failures++;
        $display("FAIL b2b_addr%0d got=%h exp=%h", 10 + i, read_data, exp_tab[i]);
      end
    end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe;
    do_write(2, 32'h00000000);
    @(negedge clk);
    byte_strobe = 4'b0101;
    do_write(2, 32'hAABBCCDD);
    addr = 2;
    #1;
    checks++;
    if (read_data !== 32'h00BB00DD) begin
      failures++;
      $display("FAIL strobe_0101 got=%h exp=%h", read_data, 32'h00BB00DD);
    end
    byte_strobe = 4'b0000;
    do_write(2, 32'h99999999);
    addr = 2;
    #1;
    checks++;
    if (read_data !== 32'h00BB00DD) begin
      failures++;
      $display("FAIL strobe_none got=%h exp=%h", read_data, 32'h00BB00DD);
    end
    byte_strobe = 4'b1000;
    do_write(2, 32'h11223344);
    addr = 2;
    #1;
    checks++;
    if (read_data !== 32'h11BB00DD) begin
      failures++;
      $display("FAIL strobe_1000 got=%h exp=%h", read_data, 32'h11BB00DD);
    end
    byte_strobe = 4'b1111;
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    addr         = '0;
    write_data   = '0;
    write_enable = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
    byte_strobe  = 4'b1111;
`endif
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_read_during_write();
    test_aliasing();
    test_back_to_back();
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
